// File: rtl/logic_gates_pipe_pkg.sv
// Shared types for the pipelined gate block: the opcode enumeration used by
// the combinational core and the pipeline top.
package logic_gates_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

endpackage

// File: rtl/logic_gates_pipe_if.sv
// Operand/result bus of the gate pipeline: input beat with valid/ready,
// result beat with valid/ready plus reduction flags and accumulator view.
interface logic_gates_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_zero;
    logic             y_parity;
    logic [WIDTH-1:0] acc_q;

    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, y, y_zero, y_parity, acc_q
    );

    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, y, y_zero, y_parity, acc_q
    );
endinterface

// File: rtl/logic_gates_pipe_core.sv
// Purely combinational bitwise operation unit; every opcode acts
// independently on each bit position.
module logic_gates_core
    import logic_gates_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_NAND:  result_o = ~(a_i & b_i);
            OP_NOR:   result_o = ~(a_i | b_i);
            OP_XOR:   result_o = a_i ^ b_i;
            OP_XNOR:  result_o = ~(a_i ^ b_i);
            OP_NOTA:  result_o = ~a_i;
            OP_PASSB: result_o = b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_gates_pipe.sv
// Two-stage pipelined gate block with valid/ready on both sides, result
// reduction flags, and an accumulator that can stand in for operand b.
module logic_gates_pipe
    import logic_gates_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input logic          clk,
    input logic          rst,
    logic_gates_if.slave bus
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_res_q, s1_res_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_zero_q, y_zero_d;
    logic             y_parity_q, y_parity_d;
    logic [WIDTH-1:0] acc_reg_q, acc_reg_d;

    logic             s2_free;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] core_res;
    op_e              op_sel;

    // Ready depends only on pipe occupancy and out_ready, never on in_valid.
    assign s2_free  = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = bus.in_valid && in_ready;
    assign b_sel    = bus.acc_en ? acc_reg_q : bus.b;
    assign op_sel   = op_e'(bus.op);

    logic_gates_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i     (op_sel),
        .a_i      (bus.a),
        .b_i      (b_sel),
        .result_o (core_res)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_res_d    = s1_res_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_zero_d    = y_zero_q;
        y_parity_d  = y_parity_q;
        acc_reg_d   = acc_reg_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_res_d   = core_res;
        end else if (s2_free) begin
            s1_valid_d = 1'b0;
        end

        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d        = s1_res_q;
                y_zero_d   = ~|s1_res_q;
                y_parity_d = ^s1_res_q;
            end
        end

        // Clear takes priority over an accumulate write-back on the same edge.
        if (bus.acc_clr) begin
            acc_reg_d = ACC_INIT;
        end else if (accept && bus.acc_en) begin
            acc_reg_d = core_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_res_q    <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_zero_q    <= 1'b1;
            y_parity_q  <= 1'b0;
            acc_reg_q   <= ACC_INIT;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_res_q    <= s1_res_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_zero_q    <= y_zero_d;
            y_parity_q  <= y_parity_d;
            acc_reg_q   <= acc_reg_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.y_zero    = y_zero_q;
    assign bus.y_parity  = y_parity_q;
    assign bus.acc_q     = acc_reg_q;

endmodule

// File: tb/tb_logic_gates_pipe.sv
// Bench for logic_gates_pipe: a queue-based model of a 2-deep, 2-cycle pipe
// checked every cycle, plus directed vectors with hand-computed results.
module tb_logic_gates_pipe;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_gates_if #(.WIDTH(W)) bus ();

    logic_gates_pipe #(
        .WIDTH    (W),
        .ACC_INIT (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] y;
        int         edge_no;
    } beat_t;

    beat_t      q[$];
    logic [7:0] log_q[$];
    int         total = 0;
    int         bad = 0;
    int         edge_n = 0;
    logic [7:0] acc_m = 8'h00;
    bit         post_rst = 1'b0;
    bit         last_acc = 1'b0;

    function automatic logic [7:0] model_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Runs just before each rising edge: compares outputs with the model, then
    // advances the model by what that edge will do.
    task automatic check_cycle();
        beat_t      nb;
        logic [7:0] bsel;
        last_acc = 1'b0;
        if (rst) begin
            q.delete();
            acc_m    = 8'h00;
            post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                chk("rst_y", bus.y, 8'h00);
                chk("rst_y_zero", bus.y_zero, 1'b1);
                chk("rst_y_parity", bus.y_parity, 1'b0);
                chk("rst_acc", bus.acc_q, 8'h00);
                chk("rst_in_ready", bus.in_ready, 1'b1);
                post_rst = 1'b0;
            end
            chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
            chk("out_valid", bus.out_valid, (q.size() > 0) && (q[0].edge_no < edge_n));
            if (bus.out_valid && q.size() > 0) begin
                chk("y", bus.y, q[0].y);
                chk("y_zero", bus.y_zero, q[0].y == 8'h00);
                chk("y_parity", bus.y_parity, ^q[0].y);
            end
            chk("acc_q", bus.acc_q, acc_m);
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                log_q.push_back(bus.y);
                void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                bsel       = bus.acc_en ? acc_m : bus.b;
                nb.y       = model_op(bus.op, bus.a, bsel);
                nb.edge_no = edge_n + 1;
                q.push_back(nb);
                last_acc = 1'b1;
                if (bus.acc_en) acc_m = nb.y;
            end
            if (bus.acc_clr) acc_m = 8'h00;
        end
        edge_n++;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc_en, input logic acc_clr);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.acc_en   = acc_en;
        bus.acc_clr  = acc_clr;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept want accept within 50 cycles");
        end
        bus.in_valid = 1'b0;
        bus.acc_en   = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [7:0] e1[8] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'h3A};
    logic [7:0] e2[4] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
    logic [7:0] e3[3] = '{8'h11, 8'h22, 8'h44};
    logic [7:0] e4[4] = '{8'h01, 8'h03, 8'h07, 8'hF8};
    logic [7:0] a3[3] = '{8'h10, 8'h20, 8'h40};
    logic [7:0] b3[3] = '{8'h01, 8'h02, 8'h04};

    initial begin
        int k;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.acc_en    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        drain(3);
        rst = 1'b0;

        // Every opcode on C5/3A.
        log_q.delete();
        for (int i = 0; i < 8; i++) send(3'(i), 8'hC5, 8'h3A, 1'b0, 1'b0);
        drain(4);
        chk("t1_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < log_q.size()) chk($sformatf("t1_op%0d", i), log_q[i], e1[i]);

        // Back-to-back XOR stream.
        log_q.delete();
        for (int i = 0; i < 4; i++) send(3'd4, 8'(i * 8'h11), 8'h0F, 1'b0, 1'b0);
        drain(4);
        chk("t2_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size()) chk($sformatf("t2_beat%0d", i), log_q[i], e2[i]);

        // Backpressure: 3 OR beats, consumer stalled.
        log_q.delete();
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            bus.op = 3'd1; bus.a = a3[k]; bus.b = b3[k]; bus.in_valid = 1'b1;
            cycle();
            if (last_acc) k++;
        end
        chk("t3_accepts_stalled", k, 2);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 3; c++) begin
            bus.op = 3'd1; bus.a = a3[k]; bus.b = b3[k]; bus.in_valid = 1'b1;
            cycle();
            if (last_acc) k++;
        end
        bus.in_valid = 1'b0;
        drain(4);
        chk("t3_count", log_q.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < log_q.size()) chk($sformatf("t3_beat%0d", i), log_q[i], e3[i]);

        // Accumulate chain and clear colliding with an accumulate beat.
        log_q.delete();
        bus.acc_clr = 1'b1;
        cycle();
        bus.acc_clr = 1'b0;
        send(3'd1, 8'h01, 8'hAA, 1'b1, 1'b0);
        send(3'd1, 8'h02, 8'hAA, 1'b1, 1'b0);
        send(3'd1, 8'h04, 8'hAA, 1'b1, 1'b0);
        chk("t4_acc07", bus.acc_q, 8'h07);
        send(3'd4, 8'hFF, 8'h55, 1'b1, 1'b1);
        chk("t4_acc_cleared", bus.acc_q, 8'h00);
        drain(4);
        chk("t4_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size()) chk($sformatf("t4_beat%0d", i), log_q[i], e4[i]);

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        send(3'd1, 8'h5A, 8'h00, 1'b1, 1'b0);
        send(3'd4, 8'hFF, 8'h00, 1'b1, 1'b0);
        chk("t5_acc_before_rst", bus.acc_q, 8'hA5);
        log_q.delete();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drain(6);
        chk("t5_no_stale", log_q.size(), 0);

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.op        = 3'($urandom_range(0, 7));
            bus.a         = 8'($urandom);
            bus.b         = 8'($urandom);
            bus.acc_en    = ($urandom_range(0, 2) == 0);
            bus.acc_clr   = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.acc_en    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        drain(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
